// File: rtl/axi_lite_reg_slice.sv
// AXI-lite register slice: one independent 2-entry skid buffer per channel
// (AW, W, B, AR, R), so VALID/payload and READY are registered on both sides.

module axi_lite_skid #(
  parameter int WIDTH = 8,
  parameter bit MODE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  generate
    if (MODE == 1'b0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign out_data  = in_data;
    end else begin : g_skid
      state_t           state;
      state_t           state_next;
      logic             ready_q;
      logic             valid_q;
      logic [WIDTH-1:0] out_q;
      logic [WIDTH-1:0] skid_q;
      logic             in_fire;
      logic             out_fire;
      logic             load_out_in;
      logic             load_out_skid;
      logic             load_skid;

      assign in_fire   = in_valid & ready_q;
      assign out_fire  = valid_q & out_ready;
      assign in_ready  = ready_q;
      assign out_valid = valid_q;
      assign out_data  = out_q;

      // Next-state and payload-steering decode for the EMPTY/ONE/TWO buffer.
      always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
          EMPTY: begin
            if (in_fire) begin
              load_out_in = 1'b1;
              state_next  = ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              load_out_in = 1'b1;
            end else if (in_fire) begin
              load_skid  = 1'b1;
              state_next = TWO;
            end else if (out_fire) begin
              state_next = EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              load_out_skid = 1'b1;
              state_next    = ONE;
            end
          end
          default: state_next = EMPTY;
        endcase
      end

      // State and the registered handshake flags; ready stays low through reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state   <= EMPTY;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end else begin
          state   <= state_next;
          ready_q <= (state_next != TWO);
          valid_q <= (state_next != EMPTY);
        end
      end

      // Payload registers carry no reset; they are ignored while valid is low.
      always_ff @(posedge clk) begin
        if (load_out_in) begin
          out_q <= in_data;
        end else if (load_out_skid) begin
          out_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= in_data;
        end
      end
    end
  endgenerate

endmodule

module axi_lite_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit AW_MODE    = 1'b1,
  parameter bit W_MODE     = 1'b1,
  parameter bit B_MODE     = 1'b1,
  parameter bit AR_MODE    = 1'b1,
  parameter bit R_MODE     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    master_aw_valid,
  output logic                    master_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   master_aw_addr,
  input  logic [2:0]              master_aw_prot,
  input  logic                    master_w_valid,
  output logic                    master_w_ready,
  input  logic [DATA_WIDTH-1:0]   master_w_data,
  input  logic [DATA_WIDTH/8-1:0] master_w_strb,
  output logic                    master_b_valid,
  input  logic                    master_b_ready,
  output logic [1:0]              master_b_resp,
  input  logic                    master_ar_valid,
  output logic                    master_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   master_ar_addr,
  input  logic [2:0]              master_ar_prot,
  output logic                    master_r_valid,
  input  logic                    master_r_ready,
  output logic [DATA_WIDTH-1:0]   master_r_data,
  output logic [1:0]              master_r_resp,
  output logic                    slave_aw_valid,
  input  logic                    slave_aw_ready,
  output logic [ADDR_WIDTH-1:0]   slave_aw_addr,
  output logic [2:0]              slave_aw_prot,
  output logic                    slave_w_valid,
  input  logic                    slave_w_ready,
  output logic [DATA_WIDTH-1:0]   slave_w_data,
  output logic [DATA_WIDTH/8-1:0] slave_w_strb,
  input  logic                    slave_b_valid,
  output logic                    slave_b_ready,
  input  logic [1:0]              slave_b_resp,
  output logic                    slave_ar_valid,
  input  logic                    slave_ar_ready,
  output logic [ADDR_WIDTH-1:0]   slave_ar_addr,
  output logic [2:0]              slave_ar_prot,
  input  logic                    slave_r_valid,
  output logic                    slave_r_ready,
  input  logic [DATA_WIDTH-1:0]   slave_r_data,
  input  logic [1:0]              slave_r_resp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  axi_lite_skid #(.WIDTH(ADDR_WIDTH + 3), .MODE(AW_MODE)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(master_aw_valid), .in_ready(master_aw_ready),
    .in_data({master_aw_addr, master_aw_prot}),
    .out_valid(slave_aw_valid), .out_ready(slave_aw_ready),
    .out_data({slave_aw_addr, slave_aw_prot})
  );

  axi_lite_skid #(.WIDTH(DATA_WIDTH + STRB_WIDTH), .MODE(W_MODE)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(master_w_valid), .in_ready(master_w_ready),
    .in_data({master_w_data, master_w_strb}),
    .out_valid(slave_w_valid), .out_ready(slave_w_ready),
    .out_data({slave_w_data, slave_w_strb})
  );

  axi_lite_skid #(.WIDTH(2), .MODE(B_MODE)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(slave_b_valid), .in_ready(slave_b_ready),
    .in_data(slave_b_resp),
    .out_valid(master_b_valid), .out_ready(master_b_ready),
    .out_data(master_b_resp)
  );

  axi_lite_skid #(.WIDTH(ADDR_WIDTH + 3), .MODE(AR_MODE)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(master_ar_valid), .in_ready(master_ar_ready),
    .in_data({master_ar_addr, master_ar_prot}),
    .out_valid(slave_ar_valid), .out_ready(slave_ar_ready),
    .out_data({slave_ar_addr, slave_ar_prot})
  );

  axi_lite_skid #(.WIDTH(DATA_WIDTH + 2), .MODE(R_MODE)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(slave_r_valid), .in_ready(slave_r_ready),
    .in_data({slave_r_data, slave_r_resp}),
    .out_valid(master_r_valid), .out_ready(master_r_ready),
    .out_data({master_r_data, master_r_resp})
  );

endmodule
